// File: rtl/signed_mult_ctrl.sv
// signed_mult_ctrl: sequential signed multiplier (sign-magnitude shift-add) with IDLE/LOAD/MULT/FIX/DONE control
//   Clk, reset (async, active-high); start begins a multiply from IDLE; A, B signed operands
//   ready = IDLE, busy = LOAD/MULT/FIX, done = one-cycle pulse in DONE, P = registered signed product
module signed_mult_ctrl #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     A,
  input  logic [DATA_WIDTH-1:0]     B,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   P
);
  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] MULT = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  logic [2:0]              state;
  logic [DATA_WIDTH-1:0]   a_reg, b_reg, mplier, mag_a, mag_b;
  logic [2*DATA_WIDTH-1:0] mcand, acc;
  logic [CW-1:0]           cnt;
  logic                    res_sign, last;
  // Magnitudes are unsigned, so the most negative operand maps to 2^(N-1) without overflow.
  always_comb begin
    mag_a = a_reg[DATA_WIDTH-1] ? ~a_reg + DATA_WIDTH'(1) : a_reg;
    mag_b = b_reg[DATA_WIDTH-1] ? ~b_reg + DATA_WIDTH'(1) : b_reg;
    last  = cnt == CW'(DATA_WIDTH-1);
  end
  assign ready = state == IDLE;
  assign busy  = state == LOAD || state == MULT || state == FIX;
  assign done  = state == DONE;
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      mplier   <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      res_sign <= 1'b0;
      P        <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg <= A;
          b_reg <= B;
          state <= LOAD;
        end
        LOAD: begin
          res_sign <= a_reg[DATA_WIDTH-1] ^ b_reg[DATA_WIDTH-1];
          mcand    <= {{DATA_WIDTH{1'b0}}, mag_a};
          mplier   <= mag_b;
          acc      <= '0;
          cnt      <= '0;
          state    <= MULT;
        end
        MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= last ? cnt : cnt + CW'(1);
          state  <= last ? FIX : MULT;
        end
        FIX: begin
          P     <= res_sign ? -acc : acc;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
